// File: rtl/router_term_port.sv
// router_term_port: terminal-side port of a mesh router node.
//   Ingress FIFO: terminal -> router crossbar.  Egress FIFO: router -> terminal.
//   Both FIFOs are first-word-fall-through with a registered occupancy count.
// Optional feature macro: ROUTER_TERM_ID_CHECK_EN
//   When defined, egress pushes whose destination row/col differ from this
//   node's id are discarded and counted in drop_cnt (saturating at 255).

// FWFT FIFO shared by both directions; head reads as zero while empty.
module router_term_port_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  // Full refuses a push even if a pop happens in the same cycle;
  // empty ignores a pop.
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  // Gating the head with empty makes it read zero straight out of reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage needs no reset: the count gates every observable read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module router_term_port #(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [3:0] id_row     = 4'd0,
  parameter logic [3:0] id_col     = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [pckg_sz-1:0] data_out_i_in,
  input  logic               pndng_i_in,
  output logic               popin,
  output logic [pckg_sz-1:0] data_out,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] rtr_data_out,
  output logic               rtr_pndng,
  input  logic               rtr_pop,
  input  logic [pckg_sz-1:0] rtr_data_in,
  input  logic               rtr_push,
  output logic               rtr_full,
  output logic [7:0]         drop_cnt
);
  logic w_in_full;
  logic w_in_empty;
  logic w_out_empty;
  logic w_eg_push;
  logic w_id_match;

  assign popin     = pndng_i_in & ~w_in_full;
  assign rtr_pndng = ~w_in_empty;
  assign pndng     = ~w_out_empty;

  // Destination row/col sit just below the 8-bit next-jump field.
  assign w_id_match = (rtr_data_in[pckg_sz-9 -: 4] == id_row) &&
                      (rtr_data_in[pckg_sz-13 -: 4] == id_col);

  router_term_port_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_ingress (
    .clk    (clk),
    .reset  (reset),
    .i_push (pndng_i_in),
    .i_data (data_out_i_in),
    .i_pop  (rtr_pop),
    .o_data (rtr_data_out),
    .o_empty(w_in_empty),
    .o_full (w_in_full)
  );

  router_term_port_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_egress (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_eg_push),
    .i_data (rtr_data_in),
    .i_pop  (pop),
    .o_data (data_out),
    .o_empty(w_out_empty),
    .o_full (rtr_full)
  );

`ifdef ROUTER_TERM_ID_CHECK_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  // Only a push that would otherwise have been written can count as a drop.
  assign w_eg_push = rtr_push & w_id_match;
  assign w_drop    = rtr_push & ~rtr_full & ~w_id_match;
  assign drop_cnt  = r_drop_cnt;

  // Saturating count of misaddressed packets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end
`else
  logic w_unused_id;

  // Every non-full push is written; the id compare has no consumer here.
  assign w_eg_push   = rtr_push;
  assign drop_cnt    = 8'd0;
  assign w_unused_id = w_id_match;
`endif
endmodule

// File: tb/tb_router_term_port.sv
// Testbench for router_term_port: queue-based reference model, randomized traffic.
module tb_router_term_port;
  localparam int W = 40;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_out_i_in;
  logic         pndng_i_in;
  logic         popin;
  logic [W-1:0] data_out;
  logic         pndng;
  logic         pop;
  logic [W-1:0] rtr_data_out;
  logic         rtr_pndng;
  logic         rtr_pop;
  logic [W-1:0] rtr_data_in;
  logic         rtr_push;
  logic         rtr_full;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] in_q[$];
  logic [W-1:0] eg_q[$];
  int           drops = 0;

  always #5 clk = ~clk;

  router_term_port #(.pckg_sz(W), .fifo_depth(D), .id_row(4'd2), .id_col(4'd3)) dut (
    .clk(clk), .reset(reset),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
    .data_out(data_out), .pndng(pndng), .pop(pop),
    .rtr_data_out(rtr_data_out), .rtr_pndng(rtr_pndng), .rtr_pop(rtr_pop),
    .rtr_data_in(rtr_data_in), .rtr_push(rtr_push), .rtr_full(rtr_full),
    .drop_cnt(drop_cnt)
  );

  function automatic bit id_ok(logic [W-1:0] d);
`ifdef ROUTER_TERM_ID_CHECK_EN
    return (d[W-9 -: 4] == 4'd2) && (d[W-13 -: 4] == 4'd3);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [W-1:0] mk(logic [3:0] row, logic [3:0] col, logic [23:0] pay);
    return {8'h00, row, col, pay};
  endfunction

  function automatic logic [W-1:0] qhead_in();
    return (in_q.size() > 0) ? in_q[0] : '0;
  endfunction

  function automatic logic [W-1:0] qhead_eg();
    return (eg_q.size() > 0) ? eg_q[0] : '0;
  endfunction

  // Advance one clock: decide what each side does from the current inputs
  // and queue occupancy, then apply it after the edge.
  task automatic step();
    bit ia, rp, ep, tp, dr;
    logic [W-1:0] din, rin;
    ia  = pndng_i_in && (in_q.size() < D);
    rp  = rtr_pop && (in_q.size() > 0);
    ep  = rtr_push && (eg_q.size() < D);
    dr  = 1'b0;
    if (ep && !id_ok(rtr_data_in)) begin ep = 1'b0; dr = 1'b1; end
    tp  = pop && (eg_q.size() > 0);
    din = data_out_i_in;
    rin = rtr_data_in;
    @(posedge clk);
    if (rp) void'(in_q.pop_front());
    if (ia) in_q.push_back(din);
    if (tp) void'(eg_q.pop_front());
    if (ep) eg_q.push_back(rin);
    if (dr && drops < 255) drops++;
    #1;
  endtask

  task automatic idle_inputs();
    pndng_i_in = 0; data_out_i_in = '0; pop = 0; rtr_pop = 0; rtr_push = 0; rtr_data_in = '0;
  endtask

  task automatic drain_all();
    idle_inputs();
    rtr_pop = 1; pop = 1;
    for (int i = 0; i < D + 1; i++) step();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({popin, pndng, rtr_pndng, rtr_full} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {popin, pndng, rtr_pndng, rtr_full});
    end
    checks++;
    if (data_out !== '0 || rtr_data_out !== '0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h expected zeros", data_out, rtr_data_out, drop_cnt);
    end
    pndng_i_in = 1; #1;
    checks++;
    if (popin !== 1'b1) begin errors++; $display("FAIL reset_popin_follows: got %b expected 1", popin); end
    pndng_i_in = 0;
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_ingress_basic();
    logic [W-1:0] w;
    w = 40'hAB12345678;
    pndng_i_in = 1; data_out_i_in = w; #1;
    checks++;
    if (popin !== 1'b1) begin errors++; $display("FAIL ingress_popin: got %b expected 1", popin); end
    step();
    pndng_i_in = 0; #1;
    checks++;
    if (rtr_pndng !== 1'b1 || rtr_data_out !== w) begin
      errors++; $display("FAIL ingress_head: got %b/%h expected 1/%h", rtr_pndng, rtr_data_out, w);
    end
    drain_all();
  endtask

  task automatic test_ingress_full();
    int acc;
    acc = 0;
    pndng_i_in = 1;
    for (int i = 0; i < 6; i++) begin
      data_out_i_in = {8'(i), 32'($urandom)}; #1;
      checks++;
      if (popin !== (in_q.size() < D)) begin
        errors++; $display("FAIL full_popin_%0d: got %b expected %b", i, popin, in_q.size() < D);
      end
      if (popin === 1'b1) acc++;
      step();
    end
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL full_accepted: got %0d expected 4", acc); end
    rtr_pop = 1; #1;
    checks++;
    if (popin !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle_popin: got %b expected 0", popin); end
    step();
    rtr_pop = 0; pndng_i_in = 0; #1;
    pndng_i_in = 1; #1;
    checks++;
    if (popin !== 1'b1) begin errors++; $display("FAIL full_popin_return: got %b expected 1", popin); end
    pndng_i_in = 0;
    rtr_pop = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rtr_data_out !== qhead_in()) begin
        errors++; $display("FAIL full_drain_%0d: got %h expected %h", i, rtr_data_out, qhead_in());
      end
      step();
    end
    rtr_pop = 0; #1;
    checks++;
    if (rtr_pndng !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", rtr_pndng); end
  endtask

  task automatic test_egress_order();
    logic [W-1:0] exp_w;
    for (int k = 1; k <= 3; k++) begin
      rtr_push = 1; rtr_data_in = mk(4'd2, 4'd3, 24'(k));
      step();
    end
    rtr_push = 0;
    for (int k = 1; k <= 3; k++) begin
      exp_w = mk(4'd2, 4'd3, 24'(k));
      #1;
      checks++;
      if (pndng !== 1'b1 || data_out !== exp_w) begin
        errors++; $display("FAIL egress_order_%0d: got %b/%h expected 1/%h", k, pndng, data_out, exp_w);
      end
      pop = 1; step(); pop = 0;
    end
    #1;
    checks++;
    if (pndng !== 1'b0 || data_out !== '0) begin
      errors++; $display("FAIL egress_empty: got %b/%h expected 0/0", pndng, data_out);
    end
    pop = 1; step(); pop = 0;
    rtr_push = 1; rtr_data_in = mk(4'd2, 4'd3, 24'h00BEEF); step(); rtr_push = 0; #1;
    checks++;
    if (pndng !== 1'b1 || data_out !== mk(4'd2, 4'd3, 24'h00BEEF)) begin
      errors++; $display("FAIL egress_pop_empty_ignored: got %b/%h expected 1/%h", pndng, data_out, mk(4'd2, 4'd3, 24'h00BEEF));
    end
    drain_all();
  endtask

  task automatic test_id_check();
    logic [W-1:0] a, b;
    a = mk(4'd2, 4'd3, 24'h0000AA);
    b = mk(4'd1, 4'd3, 24'h0000BB);
    rtr_push = 1; rtr_data_in = a; step();
    rtr_data_in = b; step();
    rtr_push = 0; #1;
`ifdef ROUTER_TERM_ID_CHECK_EN
    checks++;
    if (drop_cnt !== 8'd1) begin errors++; $display("FAIL id_drop_cnt: got %0d expected 1", drop_cnt); end
    checks++;
    if (data_out !== a) begin errors++; $display("FAIL id_head: got %h expected %h", data_out, a); end
    pop = 1; step(); pop = 0; #1;
    checks++;
    if (pndng !== 1'b0) begin errors++; $display("FAIL id_only_one: got %b expected 0", pndng); end
`else
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL id_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++;
    if (data_out !== a) begin errors++; $display("FAIL id_head: got %h expected %h", data_out, a); end
    pop = 1; step(); pop = 0; #1;
    checks++;
    if (pndng !== 1'b1 || data_out !== b) begin
      errors++; $display("FAIL id_second: got %b/%h expected 1/%h", pndng, data_out, b);
    end
`endif
    drain_all();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w [3];
    for (int k = 0; k < 3; k++) w[k] = mk(4'd2, 4'd3, 24'($urandom));
    rtr_push = 1;
    rtr_data_in = w[0]; step();
    rtr_data_in = w[1]; step();
    rtr_data_in = w[2]; pop = 1; #1;
    checks++;
    if (data_out !== w[0]) begin errors++; $display("FAIL b2b_head0: got %h expected %h", data_out, w[0]); end
    step();
    rtr_push = 0;
    for (int k = 1; k < 3; k++) begin
      #1;
      checks++;
      if (pndng !== 1'b1 || data_out !== w[k]) begin
        errors++; $display("FAIL b2b_head%0d: got %b/%h expected 1/%h", k, pndng, data_out, w[k]);
      end
      step();
    end
    pop = 0; #1;
    checks++;
    if (pndng !== 1'b0) begin errors++; $display("FAIL b2b_occupancy: got %b expected 0", pndng); end
    // Fill to full, then push+pop together: the push is refused.
    rtr_push = 1;
    for (int k = 0; k < D; k++) begin rtr_data_in = mk(4'd2, 4'd3, 24'(k + 16)); step(); end
    #1;
    checks++;
    if (rtr_full !== 1'b1) begin errors++; $display("FAIL eg_full: got %b expected 1", rtr_full); end
    rtr_data_in = mk(4'd2, 4'd3, 24'hFFFFFF); pop = 1; step();
    rtr_push = 0; pop = 0; #1;
    checks++;
    if (rtr_full !== 1'b0 || data_out !== mk(4'd2, 4'd3, 24'd17) || drop_cnt !== 8'(drops)) begin
      errors++; $display("FAIL eg_full_push_refused: got %b/%h/%0d expected 0/%h/%0d",
                         rtr_full, data_out, drop_cnt, mk(4'd2, 4'd3, 24'd17), drops);
    end
    drain_all();
  endtask

  task automatic test_async_reset();
    rtr_push = 1; pndng_i_in = 1;
    for (int k = 0; k < 2; k++) begin
      rtr_data_in = mk(4'd2, 4'd3, 24'($urandom)); data_out_i_in = 40'($urandom);
      step();
    end
    idle_inputs();
    #2;
    reset = 1; #1;
    checks++;
    if ({pndng, rtr_pndng, rtr_full, popin} !== 4'b0000 || data_out !== '0 || rtr_data_out !== '0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset: got %b %h %h %0d expected zeros",
                         {pndng, rtr_pndng, rtr_full, popin}, data_out, rtr_data_out, drop_cnt);
    end
    in_q.delete(); eg_q.delete(); drops = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pndng_i_in    = 1'($urandom);
      data_out_i_in = {8'($urandom), 32'($urandom)};
      rtr_pop       = ($urandom_range(0, 3) != 0);
      rtr_push      = 1'($urandom);
      rtr_data_in   = ($urandom_range(0, 1) == 0) ? mk(4'd2, 4'd3, 24'($urandom))
                                                  : {8'($urandom), 32'($urandom)};
      pop           = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (popin !== (pndng_i_in && in_q.size() < D) || rtr_pndng !== (in_q.size() > 0) ||
          pndng !== (eg_q.size() > 0) || rtr_full !== (eg_q.size() == D)) begin
        errors++; $display("FAIL rand_flags_%0d: got popin=%b rp=%b p=%b full=%b, in=%0d eg=%0d",
                           i, popin, rtr_pndng, pndng, rtr_full, in_q.size(), eg_q.size());
      end
      checks++;
      if (rtr_data_out !== qhead_in() || data_out !== qhead_eg() || drop_cnt !== 8'(drops)) begin
        errors++; $display("FAIL rand_data_%0d: got %h %h %0d expected %h %h %0d",
                           i, rtr_data_out, data_out, drop_cnt, qhead_in(), qhead_eg(), drops);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_ingress_basic();
    test_ingress_full();
    test_egress_order();
    test_id_check();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
